// File: rtl/model_stream_loader.sv
// ============================================================================
// Module  : model_stream_loader
// Brief   : Receives the Ising model image (J rows, hbias, constant, scaling)
//           as a word stream, writes J rows to weight memory, latches the rest.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module model_stream_loader #(
    parameter int NUM_SPIN    = 256,
    parameter int BITJ        = 4,
    parameter int BITH        = 4,
    parameter int DATA_W      = 64,
    parameter int CONST_BIT   = 32,
    parameter int SCALING_BIT = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_W-1:0]             in_data_i,
    output logic                          wr_valid_o,
    input  logic                          wr_ready_i,
    output logic [$clog2(NUM_SPIN)-1:0]   wr_addr_o,
    output logic [NUM_SPIN*BITJ-1:0]      wr_data_o,
    output logic [NUM_SPIN*BITH-1:0]      hbias_o,
    output logic [CONST_BIT-1:0]          constant_o,
    output logic [SCALING_BIT-1:0]        scaling_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int C_ADDR_W = $clog2(NUM_SPIN);
    localparam int C_ROW_W  = NUM_SPIN * BITJ;
    localparam int C_HB_W   = NUM_SPIN * BITH;
    localparam int C_WPR    = C_ROW_W / DATA_W;
    localparam int C_HPW    = C_HB_W / DATA_W;
    localparam int C_MAXW   = (C_WPR > C_HPW) ? C_WPR : C_HPW;
    localparam int C_CNT_W  = (C_MAXW > 1) ? $clog2(C_MAXW) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ROW_RX   = 3'd1,
        S_ROW_WR   = 3'd2,
        S_HB_RX    = 3'd3,
        S_CONST_RX = 3'd4,
        S_SCALE_RX = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [C_ADDR_W-1:0]      r_row;
    logic [C_CNT_W-1:0]       r_wcnt;
    logic [C_ROW_W-1:0]       r_rowbuf;
    logic [C_HB_W-1:0]        r_hbshadow;
    logic [C_HB_W-1:0]        w_hb_next;
    logic [C_HB_W-1:0]        r_hbias;
    logic [CONST_BIT-1:0]     r_const;
    logic [SCALING_BIT-1:0]   r_scale;
    logic                     r_err;

    logic                     w_acc;
    logic                     w_row_word_last;
    logic                     w_hb_word_last;
    logic                     w_row_last;
    logic                     w_start_ok;
    logic [SCALING_BIT-1:0]   w_scale;
    logic                     w_scale_ok;

    assign w_acc           = in_valid_i && in_ready_o;
    assign w_row_word_last = (r_wcnt == C_CNT_W'(C_WPR - 1));
    assign w_hb_word_last  = (r_wcnt == C_CNT_W'(C_HPW - 1));
    assign w_row_last      = (r_row == C_ADDR_W'(NUM_SPIN - 1));
    assign w_start_ok      = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_scale         = in_data_i[SCALING_BIT-1:0];
    // Legal scale: a single set bit, no larger than 16.
    assign w_scale_ok      = (w_scale != '0) && ((w_scale & (w_scale - 1'b1)) == '0)
                             && (32'(w_scale) <= 32'd16);

    // hbias shadow with the current word merged, so the last word can land
    // in hbias_o on the very next cycle.
    always_comb begin
        w_hb_next = r_hbshadow;
        w_hb_next[r_wcnt*DATA_W +: DATA_W] = in_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready_o   = 1'b0;
        wr_valid_o   = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_state_next = S_ROW_RX;
            end
            S_ROW_RX: begin
                in_ready_o = 1'b1;
                if (w_acc && w_row_word_last) w_state_next = S_ROW_WR;
            end
            S_ROW_WR: begin
                wr_valid_o = 1'b1;
                if (wr_ready_i) w_state_next = w_row_last ? S_HB_RX : S_ROW_RX;
            end
            S_HB_RX: begin
                in_ready_o = 1'b1;
                if (w_acc && w_hb_word_last) w_state_next = S_CONST_RX;
            end
            S_CONST_RX: begin
                in_ready_o = 1'b1;
                if (w_acc) w_state_next = S_SCALE_RX;
            end
            S_SCALE_RX: begin
                in_ready_o = 1'b1;
                if (w_acc) w_state_next = S_DONE;
            end
            S_DONE: begin
                busy_o       = 1'b0;
                done_o       = 1'b1;
                w_state_next = start_i ? S_ROW_RX : S_IDLE;
            end
            default: begin
                busy_o       = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_row      <= '0;
            r_wcnt     <= '0;
            r_rowbuf   <= '0;
            r_hbshadow <= '0;
            r_hbias    <= '0;
            r_const    <= '0;
            r_scale    <= SCALING_BIT'(1);
            r_err      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_row  <= '0;
                r_wcnt <= '0;
                r_err  <= 1'b0;
            end
            case (r_state)
                S_ROW_RX: if (w_acc) begin
                    r_rowbuf[r_wcnt*DATA_W +: DATA_W] <= in_data_i;
                    r_wcnt <= w_row_word_last ? '0 : r_wcnt + 1'b1;
                end
                S_ROW_WR: if (wr_ready_i) begin
                    r_row <= r_row + 1'b1;
                end
                S_HB_RX: if (w_acc) begin
                    r_hbshadow <= w_hb_next;
                    r_wcnt     <= w_hb_word_last ? '0 : r_wcnt + 1'b1;
                    if (w_hb_word_last) r_hbias <= w_hb_next;
                end
                S_CONST_RX: if (w_acc) begin
                    r_const <= in_data_i[CONST_BIT-1:0];
                end
                S_SCALE_RX: if (w_acc) begin
                    if (w_scale_ok) r_scale <= w_scale;
                    else            r_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_addr_o  = r_row;
    assign wr_data_o  = r_rowbuf;
    assign hbias_o    = r_hbias;
    assign constant_o = r_const;
    assign scaling_o  = r_scale;
    assign err_o      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_model_stream_loader.sv
// ============================================================================
// Module  : tb_model_stream_loader
// Brief   : Table-driven bench for model_stream_loader (4 spins, 8-bit words).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_model_stream_loader;

    logic        clk = 1'b0;
    logic        rst_i, start_i, in_valid_i, in_ready_o;
    logic [7:0]  in_data_i;
    logic        wr_valid_o, wr_ready_i;
    logic [1:0]  wr_addr_o;
    logic [15:0] wr_data_o, hbias_o;
    logic [7:0]  constant_o;
    logic [4:0]  scaling_o;
    logic        busy_o, done_o, err_o;

    model_stream_loader #(
        .NUM_SPIN(4), .BITJ(4), .BITH(4), .DATA_W(8), .CONST_BIT(8), .SCALING_BIT(5)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .hbias_o(hbias_o), .constant_o(constant_o),
        .scaling_o(scaling_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][15:0] rows;
        logic [15:0]      hb;
        logic [7:0]       cst;
        logic [7:0]       scl;
        logic             gaps;
        logic             stall;
        logic             mid;
        logic [4:0]       exp_scale;
        logic             exp_err;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          wn = 0;
    logic [1:0]  la [16];
    logic [15:0] ld [16];
    int          stall_left = 0;
    logic [1:0]  hold_a;
    logic [15:0] hold_d;
    logic [15:0] prev_hb;
    vec_t        vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] rows, input logic [15:0] hb,
                                input logic [7:0] cst, input logic [7:0] scl,
                                input logic gaps, input logic stall, input logic mid,
                                input logic [4:0] es, input logic ee);
        vec_t v;
        v.rows = rows; v.hb = hb; v.cst = cst; v.scl = scl;
        v.gaps = gaps; v.stall = stall; v.mid = mid;
        v.exp_scale = es; v.exp_err = ee;
        return v;
    endfunction

    // Memory-side stall on row 2, with stability checks while held off.
    always @(negedge clk) begin
        if (stall_left > 0 && wr_valid_o && wr_addr_o == 2'd2) begin
            if (stall_left == 5) begin
                hold_a = wr_addr_o;
                hold_d = wr_data_o;
            end else begin
                chk("stall_addr", 64'(wr_addr_o), 64'(hold_a));
                chk("stall_data", 64'(wr_data_o), 64'(hold_d));
            end
            chk("stall_in_ready", 64'(in_ready_o), 64'd0);
            wr_ready_i = 1'b0;
            stall_left--;
        end else begin
            wr_ready_i = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (in_valid_i && in_ready_o) acc_cnt++;
        if (done_o) done_cnt++;
        if (wr_valid_o && wr_ready_i && wn < 16) begin
            la[wn] = wr_addr_o;
            ld[wn] = wr_data_o;
            wn++;
        end
    end

    task automatic send_word(input logic [7:0] d, input logic gaps);
        int bound;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = d;
        bound = 0;
        while (!in_ready_o && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 200) chk("word_timeout", 64'd1, 64'd0);
        @(negedge clk);
        in_valid_i = 1'b0;
        in_data_i  = 8'hEE;
    endtask

    task automatic do_load(input vec_t v);
        wn = 0; acc_cnt = 0; done_cnt = 0;
        stall_left = v.stall ? 5 : 0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_err_clr", 64'(err_o), 64'd0);
        chk("start_busy", 64'(busy_o), 64'd1);
        for (int r = 0; r < 4; r++) begin
            send_word(v.rows[r][7:0], v.gaps);
            send_word(v.rows[r][15:8], v.gaps);
            chk("row_wr_lat", 64'(wr_valid_o), 64'd1);
            if (v.mid && r == 1) begin
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
        end
        send_word(v.hb[7:0], v.gaps);
        chk("hbias_atomic", 64'(hbias_o), 64'(prev_hb));
        send_word(v.hb[15:8], v.gaps);
        chk("hbias_upd", 64'(hbias_o), 64'(v.hb));
        send_word(v.cst, v.gaps);
        send_word(v.scl, v.gaps);
        chk("done_lat", 64'(done_o), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(done_o), 64'd0);
        chk("busy_idle", 64'(busy_o), 64'd0);
        chk("write_count", 64'(wn), 64'd4);
        for (int r = 0; r < 4; r++) begin
            chk("wr_addr", 64'(la[r]), 64'(r));
            chk("wr_data", 64'(ld[r]), 64'(v.rows[r]));
        end
        chk("constant", 64'(constant_o), 64'(v.cst));
        chk("scaling", 64'(scaling_o), 64'(v.exp_scale));
        chk("err", 64'(err_o), 64'(v.exp_err));
        chk("word_count", 64'(acc_cnt), 64'd12);
        chk("done_count", 64'(done_cnt), 64'd1);
        prev_hb = v.hb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_before;
        vecs[0] = mk({16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 16'hA5C3, 8'hF6, 8'h03, 1, 0, 0, 5'd1,  1);
        vecs[1] = mk({16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 16'hA5C3, 8'hF6, 8'h04, 0, 0, 0, 5'd4,  0);
        vecs[2] = mk({16'h6978, 16'h4B5A, 16'h2D3C, 16'h0F1E}, 16'h1E2D, 8'h7F, 8'h10, 0, 1, 0, 5'd16, 0);
        vecs[3] = mk({16'h00FF, 16'h8000, 16'h0001, 16'hFFFF}, 16'h0F0F, 8'h80, 8'h00, 1, 0, 1, 5'd16, 1);
        vecs[4] = mk({16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 16'h3C5A, 8'h01, 8'hE8, 0, 0, 0, 5'd8,  0);

        rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = 8'hEE;
        prev_hb = 16'h0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_scaling", 64'(scaling_o), 64'd1);
        chk("rst_outs", {hbias_o, wr_data_o, constant_o, 3'b0, wr_addr_o, err_o, busy_o, done_o, wr_valid_o, in_ready_o},
            64'd0);

        for (int i = 0; i < 5; i++) do_load(vecs[i]);
        chk("const_signed", 64'($signed(vecs[1].cst) == -10), 64'd1);

        // Extra words offered in IDLE must not be taken.
        acc_before = acc_cnt;
        in_valid_i = 1'b1; in_data_i = 8'h55;
        repeat (4) @(negedge clk);
        in_valid_i = 1'b0;
        chk("idle_no_consume", 64'(acc_cnt), 64'(acc_before));

        // Reset after row 1 has been written.
        wn = 0;
        start_i = 1'b1; @(negedge clk); start_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            send_word(vecs[1].rows[r][7:0], 1'b0);
            send_word(vecs[1].rows[r][15:8], 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("pre_rst_writes", 64'(wn), 64'd2);
        rst_i = 1'b1; @(negedge clk); rst_i = 1'b0;
        prev_hb = 16'h0;
        chk("midrst_scaling", 64'(scaling_o), 64'd1);
        chk("midrst_outs", {hbias_o, wr_data_o, constant_o, 3'b0, wr_addr_o, err_o, busy_o, done_o, wr_valid_o, in_ready_o},
            64'd0);
        acc_before = acc_cnt;
        in_valid_i = 1'b1; in_data_i = 8'h77;
        repeat (6) @(negedge clk);
        in_valid_i = 1'b0;
        chk("midrst_no_write", 64'(wn), 64'd2);
        chk("midrst_no_consume", 64'(acc_cnt), 64'(acc_before));

        do_load(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
